ntsc_word_packer: RTL

- Sits between the NTSC decoder's pixel stream and memory_interface's NTSC write port.
- Packs pairs of horizontally adjacent pixels into one memory word, with the even-x pixel in the high half.
- Buffers words in a small FIFO and presents them on the ntsc_flag/ntsc_pixel/done_ntsc handshake.
- Issues frame_flag so that buffer rotation and the address reset happen only between frames, never mid-word.

---
 rtl/ntsc_word_packer_pkg.sv | 35 +++
 rtl/ntsc_word_fifo.sv | 65 ++++++
 rtl/ntsc_word_packer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/ntsc_word_packer_pkg.sv
// Shared types and constants for the NTSC word packer.
// The pixel and word widths, the FIFO entry layout, and the two FSM
// state encodings are defined here.
package ntsc_word_packer_pkg;

  localparam int PIX_W = 18;
  localparam int MEM_W = 2 * PIX_W;

  // One FIFO entry: the start-of-frame marker travels with the word it precedes.
  typedef struct packed {
    logic             sof;
    logic [PIX_W-1:0] hi;
    logic [PIX_W-1:0] lo;
  } fifo_entry_t;

  typedef enum logic [0:0] {
    S_WAIT_SOF = 1'b0,
    S_RUN      = 1'b1
  } in_state_t;

  typedef enum logic [1:0] {
    O_IDLE  = 2'd0,
    O_FRAME = 2'd1,
    O_WRITE = 2'd2
  } out_state_t;

  // Coordinate-derived pixel value: line number above the pixel-pair index.
  function automatic logic [PIX_W-1:0] test_pattern(input logic [8:0] x_pair,
                                                    input logic [8:0] y);
    logic [17:0] raw;
    raw = {y, x_pair};
    return PIX_W'(raw);
  endfunction

endpackage

// File: rtl/ntsc_word_fifo.sv
// Small synchronous word FIFO for the NTSC packer.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
// clr_sof_i clears the sof bit of the head entry in place.
module ntsc_word_fifo
  import ntsc_word_packer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_i,
  input  fifo_entry_t              wdata_i,
  input  logic                     pop_i,
  input  logic                     clr_sof_i,
  output fifo_entry_t              head_o,
  output logic                     next_sof_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  fifo_entry_t   mem [DEPTH];
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [AW:0]   level_q, level_d;
  logic          do_push;
  logic          do_pop;

  assign empty_o    = (level_q == '0);
  assign full_o     = (level_q == (AW+1)'(DEPTH));
  assign level_o    = level_q;
  assign head_o     = mem[rd_q];
  assign next_sof_o = mem[rd_q + AW'(1)].sof;

  // Qualify requests against occupancy; a pop frees a slot for a same-cycle push.
  always_comb begin
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    rd_d    = do_pop  ? rd_q + AW'(1) : rd_q;
    wr_d    = do_push ? wr_q + AW'(1) : wr_q;
    level_d = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clock) begin
    if (clr_sof_i && !empty_o) mem[rd_q].sof <= 1'b0;
    if (do_push) mem[wr_q] <= wdata_i;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      level_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/ntsc_word_packer.sv
// Packs horizontally adjacent NTSC pixels into memory words (even-x pixel in
// the high half), queues them, and hands them to the memory write port with a
// frame pulse ahead of the first word of each frame.
// Optional build macro NTSC_WORD_PACKER_TEST_PATTERN_EN adds test_sel, which
// substitutes a coordinate-derived pattern for the pixel data.
module ntsc_word_packer
  import ntsc_word_packer_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          pix_valid,
  input  logic [PIX_W-1:0]              pix_data,
  input  logic [9:0]                    pix_x,
  input  logic [8:0]                    pix_y,
  input  logic                          frame_start,
`ifdef NTSC_WORD_PACKER_TEST_PATTERN_EN
  input  logic                          test_sel,
`endif
  input  logic                          done_ntsc,
  output logic                          ntsc_flag,
  output logic [MEM_W-1:0]              ntsc_pixel,
  output logic                          frame_flag,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam logic [9:0] IMG_W_L = 10'(IMG_W);
  localparam logic [8:0] IMG_H_L = 9'(IMG_H);
  localparam int         LW      = $clog2(FIFO_DEPTH) + 1;

  in_state_t        in_state_q, in_state_d;
  out_state_t       out_state_q, out_state_d;
  logic             half_valid_q, half_valid_d;
  logic [PIX_W-1:0] hi_half_q, hi_half_d;
  logic             sof_pending_q, sof_pending_d;
  logic             overflow_q, overflow_d;

  logic             accept;
  logic             push_req;
  logic             push;
  logic             pop;
  logic             clr_sof;
  logic [PIX_W-1:0] pix_word;
  fifo_entry_t      push_entry;
  fifo_entry_t      head;
  logic             next_sof;
  logic             fifo_full;
  logic             fifo_empty;

`ifdef NTSC_WORD_PACKER_TEST_PATTERN_EN
  assign pix_word = test_sel ? test_pattern(pix_x[9:1], pix_y) : pix_data;
`else
  assign pix_word = pix_data;
`endif

  assign accept     = (in_state_q == S_RUN) && pix_valid &&
                      (pix_x < IMG_W_L) && (pix_y < IMG_H_L);
  assign push_req   = accept && pix_x[0] && half_valid_q;
  assign push       = push_req && (!fifo_full || pop);
  assign push_entry = '{sof: sof_pending_q, hi: hi_half_q, lo: pix_word};

  // Input side: pair pixels, then let frame_start override the pair state.
  always_comb begin
    in_state_d    = in_state_q;
    half_valid_d  = half_valid_q;
    hi_half_d     = hi_half_q;
    sof_pending_d = sof_pending_q;
    overflow_d    = overflow_q;
    case (in_state_q)
      S_WAIT_SOF: begin
        if (frame_start) begin
          in_state_d    = S_RUN;
          sof_pending_d = 1'b1;
          half_valid_d  = 1'b0;
        end
      end
      default: begin
        if (accept && !pix_x[0]) begin
          hi_half_d    = pix_word;
          half_valid_d = 1'b1;
        end
        if (push_req) begin
          half_valid_d = 1'b0;
          // A dropped word leaves sof_pending untouched so the marker survives.
          if (push) sof_pending_d = 1'b0;
          else      overflow_d    = 1'b1;
        end
        if (frame_start) begin
          half_valid_d  = 1'b0;
          sof_pending_d = 1'b1;
        end
      end
    endcase
  end

  // Output side: frame pulse ahead of any sof-tagged word, then the write handshake.
  always_comb begin
    out_state_d = out_state_q;
    pop         = 1'b0;
    clr_sof     = 1'b0;
    case (out_state_q)
      O_IDLE: begin
        if (!fifo_empty) out_state_d = head.sof ? O_FRAME : O_WRITE;
      end
      O_FRAME: begin
        clr_sof     = 1'b1;
        out_state_d = O_WRITE;
      end
      O_WRITE: begin
        if (done_ntsc) begin
          pop = 1'b1;
          if (fifo_level > LW'(1)) out_state_d = next_sof ? O_FRAME : O_WRITE;
          else                     out_state_d = O_IDLE;
        end
      end
      default: out_state_d = O_IDLE;
    endcase
  end

  // State registers for both FSMs and the pairing context.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      in_state_q    <= S_WAIT_SOF;
      out_state_q   <= O_IDLE;
      half_valid_q  <= 1'b0;
      hi_half_q     <= '0;
      sof_pending_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      in_state_q    <= in_state_d;
      out_state_q   <= out_state_d;
      half_valid_q  <= half_valid_d;
      hi_half_q     <= hi_half_d;
      sof_pending_q <= sof_pending_d;
      overflow_q    <= overflow_d;
    end
  end

  ntsc_word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push_i     (push),
    .wdata_i    (push_entry),
    .pop_i      (pop),
    .clr_sof_i  (clr_sof),
    .head_o     (head),
    .next_sof_o (next_sof),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .level_o    (fifo_level)
  );

  assign ntsc_flag  = (out_state_q == O_WRITE);
  assign frame_flag = (out_state_q == O_FRAME);
  assign ntsc_pixel = ntsc_flag ? {head.hi, head.lo} : '0;
  assign overflow   = overflow_q;

endmodule
